// File: rtl/slot_bus_master.sv
// Slot bus initiator: queues read/write commands and issues one registered cs strobe per command.
// Strobe occurs 1 cycle after pop; cmd_ready drops when the FIFO is full and reads stall in RESP until rsp_ready.
// Define SLOT_MASTER_RDLAT_EN to add a WAIT cycle for slots with registered read data.
module slot_cmd_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  // Generic single-clock FIFO with an occupancy counter; DEPTH must be a power of two.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push_fire, pop_fire;

  assign push_rdy  = (count != CW'(DEPTH));
  assign pop_vld   = (count != '0);
  assign pop_dat   = mem[rd_ptr];
  assign push_fire = push_vld & push_rdy;
  assign pop_fire  = pop_vld & pop_rdy;

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module slot_bus_master #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [4:0]  addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic [15:0] txn_count
);
  typedef struct packed {
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

`ifdef SLOT_MASTER_RDLAT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, WAIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  cmd_t        cmd_in, head;
  logic        head_vld, head_pop;
  logic        cs_d, read_d, write_d, rsp_valid_d;
  logic [4:0]  addr_d;
  logic [31:0] wr_data_d, rsp_rdata_d;
  logic [15:0] txn_count_d;

  assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  slot_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (cmd_valid),
    .push_rdy (cmd_ready),
    .push_dat (cmd_in),
    .pop_vld  (head_vld),
    .pop_rdy  (head_pop),
    .pop_dat  (head)
  );

  // Slot outputs are computed here and only ever leave through registers.
  always_comb begin
    state_d     = state_q;
    head_pop    = 1'b0;
    cs_d        = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_d      = addr;
    wr_data_d   = wr_data;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    txn_count_d = txn_count;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          head_pop = 1'b1;
          cs_d     = 1'b1;
          write_d  = head.write;
          read_d   = ~head.write;
          addr_d   = head.addr;
          if (head.write) wr_data_d = head.wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        txn_count_d = txn_count + 16'd1;
        if (write) begin
          state_d = IDLE;
        end else begin
`ifdef SLOT_MASTER_RDLAT_EN
          state_d = WAIT;
`else
          rsp_rdata_d = rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`endif
        end
      end
`ifdef SLOT_MASTER_RDLAT_EN
      WAIT: begin
        rsp_rdata_d = rd_data;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cs        <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      txn_count <= '0;
    end else begin
      state_q   <= state_d;
      cs        <= cs_d;
      read      <= read_d;
      write     <= write_d;
      addr      <= addr_d;
      wr_data   <= wr_data_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      txn_count <= txn_count_d;
    end
  end
endmodule

// File: tb/tb_slot_bus_master.sv
// Directed bench for slot_bus_master: reset, single write/read, FIFO fill/drain, back-to-back writes, reset mid-response.
module tb_slot_bus_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] txn_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SLOT_MASTER_RDLAT_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  always #5 clk = ~clk;

  // Slot stub: register at address k reads back 10*k.
  assign rd_data = 32'(addr) * 32'd10;

  slot_bus_master #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .txn_count(txn_count)
  );

  task automatic push(input logic w, input logic [4:0] a, input logic [31:0] d);
    int waited = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL push_timeout addr=%0d cmd_ready=%b exp=1", a, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; #10; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #10 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({cs, read, write, rsp_valid, cmd_ready} !== 5'b00001) begin n_err++; $display("FAIL reset_flags got=%b exp=00001", {cs, read, write, rsp_valid, cmd_ready}); end
    n_cmp++; if (addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%0h exp=0", addr); end
    n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rsp_rdata got=%0h exp=0", rsp_rdata); end
    n_cmp++; if (txn_count !== 16'd0) begin n_err++; $display("FAIL reset_txn_count got=%0d exp=0", txn_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    push(1'b1, 5'd0, 32'd5);
    @(negedge clk);
    n_cmp++; if (cs !== 1'b0) begin n_err++; $display("FAIL write_pre_cs got=%b exp=0", cs); end
    @(negedge clk);
    n_cmp++; if ({cs, write, read} !== 3'b110) begin n_err++; $display("FAIL write_strobe got=%b exp=110", {cs, write, read}); end
    n_cmp++; if (addr !== 5'd0 || wr_data !== 32'd5) begin n_err++; $display("FAIL write_bus got addr=%0h data=%0h exp addr=0 data=5", addr, wr_data); end
    @(negedge clk);
    n_cmp++; if ({cs, write} !== 2'b00) begin n_err++; $display("FAIL write_post_strobe got=%b exp=00", {cs, write}); end
    n_cmp++; if (txn_count !== 16'd1) begin n_err++; $display("FAIL write_txn_count got=%0d exp=1", txn_count); end
    n_cmp++; if (wr_data !== 32'd5) begin n_err++; $display("FAIL write_hold_data got=%0h exp=5", wr_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    push(1'b0, 5'd1, 32'hDEAD);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({cs, write, read} !== 3'b101) begin n_err++; $display("FAIL read_strobe got=%b exp=101", {cs, write, read}); end
    n_cmp++; if (addr !== 5'd1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL read_addr got addr=%0h vld=%b exp addr=1 vld=0", addr, rsp_valid); end
    n_cmp++; if (wr_data !== 32'd5) begin n_err++; $display("FAIL read_keeps_wr_data got=%0h exp=5", wr_data); end
    repeat (RL) begin
      @(negedge clk);
      n_cmp++; if ({cs, read, rsp_valid} !== 3'b000) begin n_err++; $display("FAIL read_wait_state got=%b exp=000", {cs, read, rsp_valid}); end
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA) begin n_err++; $display("FAIL read_rsp got vld=%b data=%0h exp vld=1 data=a", rsp_valid, rsp_rdata); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA || cs !== 1'b0) begin n_err++; $display("FAIL read_rsp_hold got vld=%b data=%0h cs=%b exp 1/a/0", rsp_valid, rsp_rdata, cs); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL read_rsp_taken got=%b exp=0", rsp_valid); end
    n_cmp++; if (txn_count !== 16'd2) begin n_err++; $display("FAIL read_txn_count got=%0d exp=2", txn_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_and_drain();
    logic [31:0] exp_data [5] = '{32'd20, 32'd30, 32'd40, 32'd50, 32'd60};
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 5'(2 + i), 32'd0);
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_cmd_ready got=%b exp=0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd20) begin n_err++; $display("FAIL full_first_rsp got vld=%b data=%0d exp vld=1 data=20", rsp_valid, rsp_rdata); end
    cmd_write = 1'b0; cmd_addr = 5'd7; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0 || cs !== 1'b0) begin n_err++; $display("FAIL full_stall got ready=%b cs=%b exp 0/0", cmd_ready, cs); end
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      int t = 0;
      while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL drain_timeout idx=%0d rsp_valid=%b exp=1", k, rsp_valid); end
      n_cmp++; if (rsp_rdata !== exp_data[k]) begin n_err++; $display("FAIL drain_data idx=%0d got=%0d exp=%0d", k, rsp_rdata, exp_data[k]); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (txn_count !== 16'd7) begin n_err++; $display("FAIL drain_txn_count got=%0d exp=7", txn_count); end
    n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_idle got ready=%b vld=%b exp 1/0", cmd_ready, rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(1'b1, 5'd0, 32'd5);
    push(1'b1, 5'd1, 32'd10);
    @(negedge clk);
    n_cmp++; if ({cs, write} !== 2'b11 || addr !== 5'd0 || wr_data !== 32'd5) begin n_err++; $display("FAIL b2b_first got cs/wr=%b addr=%0d data=%0d exp 11/0/5", {cs, write}, addr, wr_data); end
    @(negedge clk);
    n_cmp++; if (cs !== 1'b0) begin n_err++; $display("FAIL b2b_gap got cs=%b exp=0", cs); end
    @(negedge clk);
    n_cmp++; if ({cs, write} !== 2'b11 || addr !== 5'd1 || wr_data !== 32'd10) begin n_err++; $display("FAIL b2b_second got cs/wr=%b addr=%0d data=%0d exp 11/1/10", {cs, write}, addr, wr_data); end
    @(negedge clk);
    n_cmp++; if (cs !== 1'b0 || txn_count !== 16'd2) begin n_err++; $display("FAIL b2b_done got cs=%b txn=%0d exp 0/2", cs, txn_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_resp();
    int strobes = 0;
    rsp_ready = 1'b0;
    push(1'b0, 5'd3, 32'd0);
    push(1'b0, 5'd4, 32'd0);
    push(1'b0, 5'd5, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd30) begin n_err++; $display("FAIL midrst_pre got vld=%b data=%0d exp 1/30", rsp_valid, rsp_rdata); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || cs !== 1'b0) begin n_err++; $display("FAIL midrst_immediate got vld=%b cs=%b exp 0/0", rsp_valid, cs); end
    n_cmp++; if (cmd_ready !== 1'b1 || txn_count !== 16'd0) begin n_err++; $display("FAIL midrst_state got ready=%b txn=%0d exp 1/0", cmd_ready, txn_count); end
    #10 reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cs) strobes++;
    end
    n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL midrst_strobes got=%0d exp=0", strobes); end
    n_cmp++; if (txn_count !== 16'd0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_after got txn=%0d vld=%b exp 0/0", txn_count, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fill_and_drain();
    test_back_to_back();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/slot_bus_master.md
# slot_bus_master

Initiator for the single-slot memory-mapped interface (`cs`, `read`, `write`, `addr`, `wr_data`, `rd_data`) used by the LED timer cores. It accepts read/write commands from an upstream valid/ready stream, buffers them in a small FIFO and issues one single-cycle slot strobe per command. Read data is returned on a valid/ready response channel. It replaces hand-driven bench and firmware strobes with a pipelined bus driver.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; command accepted on `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  5  slot register address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  32  captured read data.
- `cs`, `read`, `write`  out  1 each  slot strobes.
- `addr`  out  5  slot address.
- `wr_data`  out  32  slot write data.
- `rd_data`  in  32  slot read data.
- `txn_count`  out  16  strobes issued since reset.

## Operation
- FIFO is DEPTH×38 bits (`write`, `addr`, `wdata`) with a pointer and an occupancy counter.
  - `cmd_ready = (count != DEPTH)`.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- FSM states: IDLE, ISSUE, WAIT (only with macro), RESP.
  - IDLE: if FIFO is non-empty, pop the head, register `cs=1`, `addr`, `wr_data`, and `write=cmd_write` / `read=~cmd_write`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: strobes are high for exactly this cycle and `txn_count` increments.
    - Write: go to IDLE.
    - Read: sample `rd_data` into `rsp_rdata`, set `rsp_valid`, go to RESP.
  - RESP: hold `rsp_valid` and `rsp_rdata` stable. On `rsp_ready`, clear `rsp_valid` and go to IDLE. Commands keep queueing during RESP.
- Outside ISSUE, `cs`/`read`/`write` are 0, and `addr`/`wr_data` hold their last issued values.
- All slot outputs are registered; there are no combinational paths from `cmd_*` to slot outputs.
- `txn_count` wraps from 0xFFFF to 0.
- `reset` asserted at any time:
  - immediately clears the FIFO, FSM (to IDLE), strobes and `rsp_valid`;
  - discards any pending command or response.

## Timing
- Reset values:
  - `cs`, `read`, `write`, `rsp_valid` = 0;
  - `addr`, `wr_data`, `rsp_rdata`, `txn_count` = 0;
  - `cmd_ready` = 1.
- Command accepted at edge N into an empty FIFO with FSM in IDLE:
  - pop at edge N+1;
  - strobe high in the cycle between edges N+1 and N+2;
  - read data sampled at edge N+2;
  - `rsp_valid` high from edge N+2.
- Back-to-back writes issue one strobe every 2 cycles (IDLE/ISSUE alternation).
- Read throughput: one read per 3 cycles when `rsp_ready` is held at 1.
- `rsp_ready` asserted while `rsp_valid` = 0 has no effect.

## Configuration
- `SLOT_MASTER_RDLAT_EN` defined:
  - reads go ISSUE → WAIT → RESP;
  - WAIT has `cs`/`read` = 0 and samples `rd_data` at its end;
  - this supports slots with registered read data, adding one cycle of read latency.
- `SLOT_MASTER_RDLAT_EN` undefined:
  - there is no WAIT state and `rd_data` is sampled in the strobe cycle;
  - this matches combinational-read slots.
- Writes are unaffected by the macro.

## Test plan
- Reset held for 10 ns, then released → all outputs at the reset values above and `cmd_ready` = 1.
- Write `addr`=0, `wdata`=5, accepted at edge N → `cs` = `write` = 1 for exactly one cycle starting at edge N+1, with `addr`=0 and `wr_data`=5; `txn_count`=1.
- Read `addr`=1 with the slot stub driving `rd_data`=0x0000000A → `rsp_valid` at edge N+2 with `rsp_rdata`=0xA, held until `rsp_ready`. With the macro, `rsp_valid` comes one cycle later.
- `rsp_ready` held at 0 and 6 reads pushed, DEPTH=4:
  - first read goes to RESP and the next four fill the FIFO;
  - `cmd_ready` drops after the 5th accept.
- Pulsing `rsp_ready` then drains the remaining 4 responses in order.
- Writes to addr 0 (5) and addr 1 (10) pushed on consecutive cycles → two strobes 2 cycles apart, with correct `addr`/`wr_data`; `txn_count`=2.
- Reset asserted mid-RESP with 2 commands queued → `rsp_valid` = 0 immediately, no further strobes after release, `txn_count`=0.
